// File: rtl/trigger_pulse_stretch_pkg.sv
// Shared types for trigger_pulse_stretch: FSM state encoding and a sizing helper.
package trigger_pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trigger_pulse_stretch.sv
// Stretches single-cycle triggers into HIGH_N-cycle pulses separated by LOW_N-cycle gaps.
// Latency: 1 cycle trigger-to-output. Busy triggers are queued up to MAX_PEND, extras set a sticky overflow.
module trigger_pulse_stretch
    import trigger_pulse_stretch_pkg::*;
#(
    parameter int HIGH_N     = 25000000,
    parameter int LOW_N      = 25000000,
    parameter int MAX_PEND   = 15,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_trigger,
    input  logic                          i_clear,
    output logic                          o_out,
    output logic                          o_busy,
    output logic [$clog2(MAX_PEND+1)-1:0] o_pending,
    output logic                          o_overflow
);

    localparam int CNT_W  = $clog2(max_int(HIGH_N, LOW_N) + 1);
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_N - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_N - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
    localparam logic              OUT_IDLE  = (ACTIVE_LOW != 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (i_trigger) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (i_trigger) begin
                    if (pend_q == PEND_MAX) ovf_d = 1'b1;
                    else                    pend_d = pend_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    // A trigger arriving on the last gap cycle replaces the dequeued entry.
                    if (i_trigger || (pend_q != '0)) begin
                        state_d = ST_HIGH;
                        cnt_d   = HIGH_LOAD;
                        if (!i_trigger) pend_d = pend_q - 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (i_trigger) begin
                        if (pend_q == PEND_MAX) ovf_d = 1'b1;
                        else                    pend_d = pend_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (i_clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pend_d  = '0;
            ovf_d   = 1'b0;
        end

        out_d  = (state_d == ST_HIGH) ? ~OUT_IDLE : OUT_IDLE;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= OUT_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign o_out      = out_q;
    assign o_busy     = busy_q;
    assign o_pending  = pend_q;
    assign o_overflow = ovf_q;

endmodule
